// File: rtl/bg_write_combiner.sv
// bg_write_combiner
// Write-combining buffer between the background write-back path and the
// memory arbitrator. Pixel-pair writes are merged into one 8-word block
// with a per-pixel mask. The block goes out as a single masked burst when
// the block tag changes, when an explicit flush is requested, or (optionally)
// when every pixel in the block has been written.
//
// Ports
//   gpuClk         clock, rising edge
//   i_rst          asynchronous active-high reset
//   write32        pixel pair, [15:0] even pixel, [31:16] odd pixel
//   bgWriteAdr     32-bit word address; [17:3] block tag, [2:0] word in block
//   pixelValid     per-pixel enable, 2'b00 = no request
//   writePixelDone combinational accept for the current request
//   i_flushAll     level request to push out any dirty data
//   o_empty        no dirty pixels and no flush in progress
//   flushReq       registered burst request to the arbitrator
//   flushAdr       block tag of the burst
//   flushData      word i on [32i+31:32i]
//   flushMask      pixel enables, bit 2i+j = word i pixel j
//   flushAck       arbitrator accepted the burst (sampled while flushReq=1)
module bg_write_combiner #(
  parameter bit AUTO_FLUSH_FULL = 1'b1
) (
  input  logic         gpuClk,
  input  logic         i_rst,
  input  logic [31:0]  write32,
  input  logic [17:0]  bgWriteAdr,
  input  logic [1:0]   pixelValid,
  output logic         writePixelDone,
  input  logic         i_flushAll,
  output logic         o_empty,
  output logic         flushReq,
  output logic [14:0]  flushAdr,
  output logic [255:0] flushData,
  output logic [15:0]  flushMask,
  input  logic         flushAck
);

  typedef enum logic {COLLECT, FLUSH} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [14:0]   r_tag;
  logic [15:0]   r_mask;
  logic [255:0]  r_data;

  logic          w_req;
  logic          w_hit;
  logic          w_accept;
  logic          w_enter_flush;
  logic [15:0]   w_pv_mask;
  logic [14:0]   w_next_tag;
  logic [15:0]   w_next_mask;
  logic [255:0]  w_next_data;

  assign w_req     = |pixelValid;
  assign w_hit     = (r_mask != '0) && (bgWriteAdr[17:3] == r_tag);
  assign w_pv_mask = 16'(pixelValid) << {bgWriteAdr[2:0], 1'b0};

  // State register
  always_ff @(posedge gpuClk or posedge i_rst) begin
    if (i_rst) r_state <= COLLECT;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      COLLECT: begin
        if ((r_mask != '0) && (i_flushAll || (w_req && !w_hit)))
          w_next_state = FLUSH;
        else if (AUTO_FLUSH_FULL && w_accept && (w_next_mask == '1))
          w_next_state = FLUSH;
      end
      FLUSH: begin
        if (flushAck) w_next_state = COLLECT;
      end
      default: w_next_state = COLLECT;
    endcase
  end

  // Outputs / control strobes
  always_comb begin
    w_accept = (r_state == COLLECT) && !i_rst && w_req && !i_flushAll &&
               ((r_mask == '0) || w_hit);
    writePixelDone = w_accept;
    o_empty        = (r_mask == '0) && (r_state == COLLECT);
    w_enter_flush  = (r_state == COLLECT) && (w_next_state == FLUSH);
  end

  // Merged view of the buffer after this cycle's accept. The burst snapshot
  // is taken from this view so an auto-flush on the filling write carries
  // that write's pixels too.
  always_comb begin
    w_next_tag  = r_tag;
    w_next_mask = r_mask;
    w_next_data = r_data;
    if (w_accept) begin
      w_next_tag  = bgWriteAdr[17:3];
      w_next_mask = r_mask | w_pv_mask;
      if (pixelValid[0]) w_next_data[{bgWriteAdr[2:0], 5'd0}  +: 16] = write32[15:0];
      if (pixelValid[1]) w_next_data[{bgWriteAdr[2:0], 5'd16} +: 16] = write32[31:16];
    end
  end

  always_ff @(posedge gpuClk or posedge i_rst) begin
    if (i_rst) begin
      r_tag     <= '0;
      r_mask    <= '0;
      r_data    <= '0;
      flushReq  <= 1'b0;
      flushAdr  <= '0;
      flushData <= '0;
      flushMask <= '0;
    end else begin
      r_tag  <= w_next_tag;
      r_data <= w_next_data;
      if ((r_state == FLUSH) && flushAck) r_mask <= '0;
      else                                r_mask <= w_next_mask;

      if (w_enter_flush) begin
        flushReq  <= 1'b1;
        flushAdr  <= w_next_tag;
        flushData <= w_next_data;
        flushMask <= w_next_mask;
      end else if ((r_state == FLUSH) && flushAck) begin
        flushReq  <= 1'b0;
      end
    end
  end

endmodule
